// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch-stage sequencer
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        STALL,
        FLUSH,
        HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // IF/ID instruction bubble mux: a flushed slot holds addi x0,x0,0
    function automatic logic [31:0] ifid_inst_mux(input logic [31:0] inst, input logic flush);
        return flush ? NOP_INST : inst;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_cnt.sv
// rtl/fetch_ctrl_sat_cnt.sv - enable-gated counter that sticks at all-ones
module fetch_ctrl_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch/IF-ID sequencer: boot delay, redirect, flush, stall, halt
// Optional performance counters under FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall_req,
    input  logic              branch_taken,
    input  logic              halt_req,
    output logic              pc_en,
    output logic              pc_redirect,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              ifid_valid,
    output logic              halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    localparam int CNT_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic             halted_q, halted_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        pc_en        = 1'b0;
        pc_redirect  = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;

        // A taken branch overrides everything outside BOOT/HALT
        if ((state_q inside {RUN, STALL, FLUSH}) && branch_taken) begin
            pc_en        = 1'b1;
            pc_redirect  = 1'b1;
            ifid_en      = 1'b1;
            ifid_flush   = 1'b1;
            ifid_valid_d = 1'b0;
            state_d      = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            cnt_d        = FLUSH_LOAD;
        end else begin
            case (state_q)
                BOOT: begin
                    if (cnt_q == BOOT_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN, STALL: begin
                    if (halt_req) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else if (stall_req) begin
                        state_d = STALL;
                    end else begin
                        pc_en        = 1'b1;
                        ifid_en      = 1'b1;
                        ifid_valid_d = 1'b1;
                        state_d      = RUN;
                    end
                end
                FLUSH: begin
                    // Wrong-path stall/halt requests are dropped here
                    pc_en        = 1'b1;
                    ifid_en      = 1'b1;
                    ifid_flush   = 1'b1;
                    ifid_valid_d = 1'b0;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = BOOT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= BOOT;
            cnt_q        <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign halted     = halted_q;

`ifdef FETCH_CTRL_PERF_EN
    logic stall_gated;

    assign stall_gated = (state_q inside {RUN, STALL}) && stall_req && !branch_taken && !halt_req;

    fetch_ctrl_sat_cnt #(.W(PERF_W)) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (stall_gated),
        .cnt  (perf_stall_cnt)
    );

    fetch_ctrl_sat_cnt #(.W(PERF_W)) u_flush_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (ifid_flush),
        .cnt  (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl against a rule-level reference model
module tb_fetch_ctrl;

    localparam int BOOT = 4;
    localparam int FL   = 2;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic stall_req = 1'b0;
    logic branch_taken = 1'b0;
    logic halt_req = 1'b0;
    logic pc_en, pc_redirect, ifid_en, ifid_flush, ifid_valid, halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(
        .BOOT_CYCLES  (BOOT),
        .FLUSH_CYCLES (FL),
        .PERF_W       (PW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall_req      (stall_req),
        .branch_taken   (branch_taken),
        .halt_req       (halt_req),
        .pc_en          (pc_en),
        .pc_redirect    (pc_redirect),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        int pc_en;
        int redir;
        int en;
        int flush;
        int valid;
        int halted;
        int stall_cnt;
        int flush_cnt;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: cycles of boot left, bubbles left, sticky flags
    int boot_left  = BOOT;
    int flush_left = 0;
    int m_valid    = 0;
    int m_halted   = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    function automatic int sat_inc(input int x);
        return (x < PMAX) ? x + 1 : x;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic step(input bit r, input bit b, input bit h, input bit s);
        exp_t e;
        @(posedge clk);
        #1;
        rstn = r;
        branch_taken = b;
        halt_req = h;
        stall_req = s;
        e = '{default: 0};
        if (!r) begin
            boot_left  = BOOT;
            flush_left = 0;
            m_valid    = 0;
            m_halted   = 0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            e.valid     = m_valid;
            e.halted    = m_halted;
            e.stall_cnt = m_stall;
            e.flush_cnt = m_flush;
            if (boot_left > 0) begin
                boot_left--;
            end else if (m_halted != 0) begin
                // absorbing
            end else if (b) begin
                e.pc_en = 1; e.redir = 1; e.en = 1; e.flush = 1;
                m_valid = 0;
                flush_left = FL - 1;
                m_flush = sat_inc(m_flush);
            end else if (flush_left > 0) begin
                e.pc_en = 1; e.en = 1; e.flush = 1;
                m_valid = 0;
                flush_left--;
                m_flush = sat_inc(m_flush);
            end else if (h) begin
                m_halted = 1;
            end else if (s) begin
                m_stall = sat_inc(m_stall);
            end else begin
                e.pc_en = 1; e.en = 1;
                m_valid = 1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en",       int'(pc_en),       e.pc_en);
                chk("pc_redirect", int'(pc_redirect), e.redir);
                chk("ifid_en",     int'(ifid_en),     e.en);
                chk("ifid_flush",  int'(ifid_flush),  e.flush);
                chk("ifid_valid",  int'(ifid_valid),  e.valid);
                chk("halted",      int'(halted),      e.halted);
`ifdef FETCH_CTRL_PERF_EN
                chk("perf_stall_cnt", int'(perf_stall_cnt), e.stall_cnt);
                chk("perf_flush_cnt", int'(perf_flush_cnt), e.flush_cnt);
`endif
            end
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        // stall and halt while flushing are wrong-path
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(4);
        // reset in the middle of a flush
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(7);
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        repeat (400) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
